// File: rtl/mem_stage_unit.sv
// mem_stage_unit: memory stage of the pipelined ARM core.
// Executes loads/stores against an internal word RAM or a wait-stated IO bus.
// It stalls upstream while an IO access is outstanding, and every IO access is
// bounded by a timeout. It also drives the MEM/WB pipeline register.
module mem_stage_unit #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] IO_BASE     = 32'h0001_0000,
    parameter int unsigned IO_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    input  logic [3:0]  WA3M,
    input  logic        RegWriteM,
    input  logic        MemToRegM,
    input  logic        MemWriteM,
    input  logic        PCSrcM,
    input  logic        io_ack,
    input  logic [31:0] io_rdata,
    output logic        io_req,
    output logic        io_we,
    output logic [15:0] io_addr,
    output logic [31:0] io_wdata,
    output logic        StallM,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [3:0]  WA3W,
    output logic        RegWriteW,
    output logic        MemToRegW,
    output logic        PCSrcW,
    output logic        io_err
);

    localparam int unsigned AW           = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_END      = 32'(DEPTH_WORDS * 32'd4);
    localparam int unsigned CW           = $clog2(IO_TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(IO_TIMEOUT - 1);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_io_req;
    logic            r_io_we;
    logic [15:0]     r_io_addr;
    logic [31:0]     r_io_wdata;
    logic            r_io_err;
    logic [31:0]     r_read_data_w;
    logic [31:0]     r_alu_out_w;
    logic [3:0]      r_wa3_w;
    logic            r_reg_write_w;
    logic            r_mem_to_reg_w;
    logic            r_pcsrc_w;
    logic [31:0]     r_ram [DEPTH_WORDS];

    logic            w_active;
    logic            w_is_io;
    logic            w_is_ram;
    logic            w_io_access;
    logic            w_in_req;
    logic            w_timeout;
    logic            w_io_done;
    logic            w_stall;
    logic            w_ram_we;
    logic [AW-1:0]   w_ram_idx;
    logic [31:0]     w_rdata;

    // Region decode, completion detection and stall generation.
    always_comb begin
        w_active    = MemToRegM | MemWriteM;
        w_is_io     = (AddrM >= IO_BASE);
        w_is_ram    = (AddrM < RAM_END) & ~w_is_io;
        w_io_access = w_active & w_is_io;
        w_in_req    = (r_state == S_REQ);
        // An ack on the last allowed cycle wins over the timeout.
        w_timeout   = w_in_req & ~io_ack & (r_cnt == CNT_LAST);
        w_io_done   = w_in_req & (io_ack | w_timeout);
        w_stall     = w_io_access & ~w_io_done;
        w_ram_idx   = AddrM[AW+1:2];
        w_ram_we    = MemWriteM & w_is_ram;
    end

    // Load data selection for the MEM/WB register.
    always_comb begin
        w_rdata = 32'h0000_0000;
        if (w_active && w_is_io) begin
            if (w_in_req && io_ack) begin
                w_rdata = io_rdata;
            end else begin
                w_rdata = TIMEOUT_DATA;
            end
        end else if (w_active && w_is_ram) begin
            w_rdata = r_ram[w_ram_idx];
        end else begin
            w_rdata = 32'h0000_0000;
        end
    end

    // Data RAM write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_idx] <= WriteDataM;
        end
    end

    // IO access FSM: latch the request, count wait cycles, complete on ack or timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_io_req   <= 1'b0;
            r_io_we    <= 1'b0;
            r_io_addr  <= 16'h0000;
            r_io_wdata <= 32'h0000_0000;
            r_io_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_io_access) begin
                        r_state    <= S_REQ;
                        r_cnt      <= '0;
                        r_io_req   <= 1'b1;
                        r_io_we    <= MemWriteM;
                        r_io_addr  <= AddrM[15:0];
                        r_io_wdata <= WriteDataM;
                    end
                end
                S_REQ: begin
                    if (w_io_done) begin
                        // Always return through IDLE so io_req shows a gap.
                        r_state  <= S_IDLE;
                        r_io_req <= 1'b0;
                        r_io_we  <= 1'b0;
                        if (w_timeout) begin
                            r_io_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_io_req <= 1'b0;
                    r_io_we  <= 1'b0;
                end
            endcase
        end
    end

    // MEM/WB pipeline register; a stall inserts a bubble so WB never repeats a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_read_data_w  <= 32'h0000_0000;
            r_alu_out_w    <= 32'h0000_0000;
            r_wa3_w        <= 4'h0;
            r_reg_write_w  <= 1'b0;
            r_mem_to_reg_w <= 1'b0;
            r_pcsrc_w      <= 1'b0;
        end else if (w_stall) begin
            r_read_data_w  <= 32'h0000_0000;
            r_alu_out_w    <= 32'h0000_0000;
            r_wa3_w        <= 4'h0;
            r_reg_write_w  <= 1'b0;
            r_mem_to_reg_w <= 1'b0;
            r_pcsrc_w      <= 1'b0;
        end else begin
            r_read_data_w  <= w_rdata;
            r_alu_out_w    <= AddrM;
            r_wa3_w        <= WA3M;
            r_reg_write_w  <= RegWriteM;
            r_mem_to_reg_w <= MemToRegM;
            r_pcsrc_w      <= PCSrcM;
        end
    end

    assign io_req    = r_io_req;
    assign io_we     = r_io_we;
    assign io_addr   = r_io_addr;
    assign io_wdata  = r_io_wdata;
    assign io_err    = r_io_err;
    assign StallM    = w_stall;
    assign ReadDataW = r_read_data_w;
    assign ALUOutW   = r_alu_out_w;
    assign WA3W      = r_wa3_w;
    assign RegWriteW = r_reg_write_w;
    assign MemToRegW = r_mem_to_reg_w;
    assign PCSrcW    = r_pcsrc_w;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Testbench for mem_stage_unit: a directed plus random instruction stream, an
// IO device model and a scoreboard of expected MEM/WB writes.
module tb_mem_stage_unit;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] IOB   = 32'h0001_0000;
    localparam int          T     = 16;
    localparam logic [31:0] RAM_END = 32'(DEPTH * 4);

    logic        clk, reset;
    logic [31:0] AddrM, WriteDataM;
    logic [3:0]  WA3M;
    logic        RegWriteM, MemToRegM, MemWriteM, PCSrcM;
    logic        io_ack;
    logic [31:0] io_rdata;
    logic        io_req, io_we;
    logic [15:0] io_addr;
    logic [31:0] io_wdata;
    logic        StallM;
    logic [31:0] ReadDataW, ALUOutW;
    logic [3:0]  WA3W;
    logic        RegWriteW, MemToRegW, PCSrcW, io_err;

    mem_stage_unit #(.DEPTH_WORDS(DEPTH), .IO_BASE(IOB), .IO_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .AddrM(AddrM), .WriteDataM(WriteDataM), .WA3M(WA3M),
        .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM), .PCSrcM(PCSrcM),
        .io_ack(io_ack), .io_rdata(io_rdata), .io_req(io_req), .io_we(io_we),
        .io_addr(io_addr), .io_wdata(io_wdata), .StallM(StallM), .ReadDataW(ReadDataW),
        .ALUOutW(ALUOutW), .WA3W(WA3W), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
        .PCSrcW(PCSrcW), .io_err(io_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [3:0]  wa3;
        logic        rw, mtr, pcs;
        logic [31:0] rdata;
        bit          chk_rdata;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_mem [int];
    bit          model_err = 1'b0;
    bit          mon_en = 1'b0;
    logic [31:0] cfg_addr = 32'h0, cfg_wdata = 32'h0, cfg_rdata = 32'h0;
    bit          cfg_we = 1'b0;
    int          cfg_ack_at = 0;
    logic [31:0] pool [8] = '{32'h0, 32'h40, 32'h7C, 32'h100, 32'h204, 32'h3FC, 32'h800, 32'hFFC};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_io_req"}, {31'd0, io_req}, 32'd0);
        chk({tag, "_io_we"}, {31'd0, io_we}, 32'd0);
        chk({tag, "_io_addr"}, {16'd0, io_addr}, 32'd0);
        chk({tag, "_io_wdata"}, io_wdata, 32'd0);
        chk({tag, "_rdata"}, ReadDataW, 32'd0);
        chk({tag, "_alu"}, ALUOutW, 32'd0);
        chk({tag, "_ctrl"}, {25'd0, WA3W, RegWriteW, MemToRegW, PCSrcW}, 32'd0);
        chk({tag, "_io_err"}, {31'd0, io_err}, 32'd0);
    endtask

    // Presents one instruction to MEM (entered just after a posedge), pushes its
    // expected WB write, holds it while stalled, and returns just after the
    // posedge that captures it.
    task automatic run_instr(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wa3, input logic rw, input logic mtr,
                             input logic mw, input logic pcs, input int ack_at,
                             input logic [31:0] rdata);
        exp_t e;
        int   exp_stall = 0;
        int   n = 0;
        bit   first = 1'b1;
        bit   active = mtr | mw;
        int   idx = int'(addr >> 2);
        e.alu = addr; e.wa3 = wa3; e.rw = rw; e.mtr = mtr; e.pcs = pcs;
        e.rdata = 32'h0; e.chk_rdata = 1'b1;
        if (active && addr >= IOB) begin
            if (ack_at >= 1 && ack_at <= T) begin
                exp_stall = ack_at;
                e.rdata   = rdata;
            end else begin
                exp_stall = T;
                e.rdata   = 32'hDEAD_BEEF;
                model_err = 1'b1;
            end
        end else if (active && addr < RAM_END) begin
            if (mw) begin
                e.chk_rdata    = 1'b0;
                model_mem[idx] = wdata;
            end else if (model_mem.exists(idx)) begin
                e.rdata = model_mem[idx];
            end else begin
                e.chk_rdata = 1'b0;
            end
        end else if (active && mw) begin
            e.chk_rdata = 1'b0;
        end
        e.err = model_err;
        cfg_addr = addr; cfg_wdata = wdata; cfg_we = mw; cfg_ack_at = ack_at; cfg_rdata = rdata;
        AddrM = addr; WriteDataM = wdata; WA3M = wa3;
        RegWriteM = rw; MemToRegM = mtr; MemWriteM = mw; PCSrcM = pcs;
        q.push_back(e);
        forever begin
            @(negedge clk); #1;
            if (first) begin
                chk("io_req_at_entry", {31'd0, io_req}, 32'd0);
                first = 1'b0;
            end
            if (!StallM) break;
            n++;
            if (n > T + 8) begin
                checks++; errors++;
                $display("FAIL stall_bound: stall exceeded %0d cycles at addr %h", n, addr);
                break;
            end
        end
        chk("stall_cycles", 32'(n), 32'(exp_stall));
        @(posedge clk); #1;
    endtask

    // IO device model: acks on the configured REQ cycle, random noise otherwise.
    initial begin
        int reqcnt = 0;
        io_ack = 1'b0;
        io_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (io_req) begin
                reqcnt++;
                chk("io_addr_hold", {16'd0, io_addr}, {16'd0, cfg_addr[15:0]});
                chk("io_we_hold", {31'd0, io_we}, {31'd0, cfg_we});
                if (cfg_we) chk("io_wdata_hold", io_wdata, cfg_wdata);
                io_ack   = (reqcnt == cfg_ack_at);
                io_rdata = io_ack ? cfg_rdata : $urandom;
            end else begin
                reqcnt   = 0;
                io_ack   = 1'($urandom_range(0, 1));
                io_rdata = $urandom;
            end
        end
    end

    // Scoreboard monitor: each non-stalled cycle yields one WB write, each stall a bubble.
    initial begin
        bit   prev_ok = 1'b0;
        bit   prev_stall = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk); #1;
            if (mon_en) begin
                if (prev_ok) begin
                    if (prev_stall) begin
                        chk("bubble_ctrl", {25'd0, WA3W, RegWriteW, MemToRegW, PCSrcW}, 32'd0);
                        chk("bubble_data", ReadDataW | ALUOutW, 32'd0);
                    end else if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wb_unexpected: WB write with empty scoreboard at %0t", $time);
                    end else begin
                        e = q.pop_front();
                        chk("wb_alu", ALUOutW, e.alu);
                        chk("wb_wa3", {28'd0, WA3W}, {28'd0, e.wa3});
                        chk("wb_ctrl", {29'd0, RegWriteW, MemToRegW, PCSrcW}, {29'd0, e.rw, e.mtr, e.pcs});
                        chk("wb_io_err", {31'd0, io_err}, {31'd0, e.err});
                        if (e.chk_rdata) chk("wb_rdata", ReadDataW, e.rdata);
                    end
                end
                prev_stall = StallM;
                prev_ok    = 1'b1;
            end else begin
                prev_ok = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        reset = 1'b1;
        AddrM = 32'h0; WriteDataM = 32'h0; WA3M = 4'h0;
        RegWriteM = 1'b0; MemToRegM = 1'b0; MemWriteM = 1'b0; PCSrcM = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        reset = 1'b0;
        mon_en = 1'b1;

        // Store then load through RAM.
        run_instr(32'h40, 32'hCAFE_0001, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0);
        run_instr(32'h40, 32'h0, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 0, 32'h0);
        foreach (pool[i]) run_instr(pool[i], $urandom, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0);
        // Region boundaries: last RAM word, first unmapped, last unmapped, 0x8000.
        run_instr(RAM_END - 32'd4, 32'h0, 4'h4, 1'b1, 1'b1, 1'b0, 1'b0, 0, 32'h0);
        run_instr(RAM_END, 32'h0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 0, 32'h0);
        run_instr(IOB - 32'd1, 32'h0, 4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 0, 32'h0);
        run_instr(32'h8000, 32'h0, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 0, 32'h0);
        // IO load acked on 3rd REQ cycle.
        run_instr(32'h0001_0010, 32'h0, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0, 3, 32'h1234_5678);
        // Two back-to-back IO loads acked on the first REQ cycle.
        run_instr(32'h0001_0020, 32'h0, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0, 1, 32'hA5A5_0001);
        run_instr(32'h0001_0024, 32'h0, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 1, 32'hA5A5_0002);
        // IO store never acked: timeout, sticky error.
        run_instr(32'h0001_0030, 32'h5555_AAAA, 4'hB, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0);
        // Ack on the final allowed cycle completes normally.
        run_instr(32'hFFFF_FFF0, 32'h0, 4'hC, 1'b1, 1'b1, 1'b0, 1'b0, T, 32'h0BAD_F00D);
        run_instr(32'h0000_1234, 32'h0, 4'hD, 1'b1, 1'b0, 1'b0, 1'b1, 0, 32'h0);

        for (int k = 0; k < 120; k++) begin
            int          kind = int'($urandom_range(0, 5));
            int          ack  = int'($urandom_range(0, 5));
            logic [31:0] a;
            logic [3:0]  wa = 4'($urandom);
            logic        rw = 1'($urandom);
            logic        pc = 1'($urandom);
            case (kind)
                0: run_instr($urandom, $urandom, wa, rw, 1'b0, 1'b0, pc, 0, 32'h0);
                1: run_instr(pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)), $urandom,
                             wa, rw, 1'b0, 1'b1, pc, 0, 32'h0);
                2: run_instr(pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)), $urandom,
                             wa, rw, 1'b1, 1'b0, pc, 0, 32'h0);
                3: begin
                    a = $urandom_range(RAM_END, IOB - 32'd1);
                    run_instr(a, $urandom, wa, rw, ~rw, rw, pc, 0, 32'h0);
                end
                4: begin
                    a = IOB + 32'($urandom_range(0, 32'hFFFF));
                    run_instr(a, $urandom, wa, rw, 1'b1, 1'b0, pc, ack, $urandom);
                end
                default: begin
                    a = IOB + 32'($urandom_range(0, 32'hFFFF));
                    run_instr(a, $urandom, wa, rw, 1'b0, 1'b1, pc, ack, $urandom);
                end
            endcase
        end

        // Reset on the 2nd REQ cycle of a never-acked IO load.
        run_instr(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        @(negedge clk); #2;
        mon_en = 1'b0;
        cfg_addr = IOB + 32'h20; cfg_we = 1'b0; cfg_ack_at = 0;
        AddrM = IOB + 32'h20; MemToRegM = 1'b1; MemWriteM = 1'b0; RegWriteM = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && seen < 2; c++) begin
            @(negedge clk); #2;
            if (io_req) seen++;
        end
        chk("req_cycles_before_reset", 32'(seen), 32'd2);
        reset = 1'b1;
        #1;
        check_zero_outputs("mid_reset");
        model_err = 1'b0;
        AddrM = 32'h0; MemToRegM = 1'b0; RegWriteM = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
        run_instr(32'h40, 32'h0, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 0, 32'h0);
        run_instr(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        @(negedge clk); #2;
        mon_en = 1'b0;
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_unit.md
# mem_stage_unit

Memory-stage engine of the pipelined ARM core. It consumes the EX/MEM pipeline-register outputs, executes loads and stores against an internal word-addressed data RAM or a wait-stated memory-mapped IO bus (camera/peripherals), and drives the MEM/WB pipeline register. It stalls the upstream pipeline while an IO access is outstanding and bounds every IO access with a timeout.

## Interface
- DEPTH_WORDS, 1024: data RAM size in 32-bit words (power of two); RAM region is byte addresses 0 .. DEPTH_WORDS*4-1
- IO_BASE, 32'h0001_0000: IO region is AddrM >= IO_BASE
- IO_TIMEOUT, 16: maximum cycles in REQ before forced completion (>= 1)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- AddrM  in  32  byte address (ALU result) of the MEM-stage instruction
- WriteDataM  in  32  store data
- WA3M  in  4  destination register
- RegWriteM, MemToRegM, MemWriteM, PCSrcM  in  1 each  control bits from EX/MEM
- io_ack  in  1  IO completion, sampled while io_req=1
- io_rdata  in  32  IO read data, valid with io_ack
- io_req  out  1  IO access request
- io_we  out  1  IO write strobe
- io_addr  out  16  AddrM[15:0], held for the whole request
- io_wdata  out  32  store data, held for the whole request
- StallM  out  1  hold IF/ID/EX and EX/MEM this cycle
- ReadDataW  out  32  load data to WB
- ALUOutW  out  32  AddrM passed through to WB
- WA3W  out  4  destination register to WB
- RegWriteW, MemToRegW, PCSrcW  out  1 each  control bits to WB
- io_err  out  1  sticky; set on any IO timeout

## Operation
- Access is active when MemToRegM=1 (load) or MemWriteM=1 (store). Region decode uses the full AddrM; AddrM[1:0] are ignored and RAM index = AddrM[log2(DEPTH_WORDS)+1:2].
- RAM region: single cycle, never stalls. A store writes RAM at the posedge. A load reads synchronously and the data lands in ReadDataW at that same edge.
- Unmapped region (between RAM end and IO_BASE): single cycle. Stores are dropped. Loads return 32'h0000_0000.
- IO region FSM, states IDLE and REQ:
  - IDLE: an active IO access asserts StallM=1 combinationally. At the next posedge the block latches io_we/io_addr/io_wdata, clears the timeout counter, and moves to REQ.
  - REQ: io_req=1. The counter increments each cycle.
  - If io_ack=1 in REQ, the access completes that cycle. StallM=0, io_rdata is captured into ReadDataW at the posedge, and the FSM returns to IDLE.
  - If the counter reaches IO_TIMEOUT-1 without io_ack, the access force-completes the same way with ReadDataW=32'hDEAD_BEEF, and io_err is set.
- StallM = IO access active AND NOT (REQ AND (io_ack OR timeout)).
- MEM/WB register:
  - When StallM=0, it captures every field at the posedge.
  - When StallM=1, it loads a bubble: RegWriteW=0, MemToRegW=0, PCSrcW=0, other fields don't-care (driven 0). This prevents WB from repeating a write.
- Non-memory instructions pass through with ReadDataW=0.

## Timing
- Reset (async): FSM=IDLE, counter=0, io_req=0, io_we=0, io_addr=0, io_wdata=0, all W outputs=0, io_err=0. StallM is combinational and follows its inputs once reset is released.
- RAM and unmapped accesses: 1-cycle latency; ReadDataW is valid the cycle after the instruction sits in MEM.
- IO access: with the instruction in MEM in cycle N, io_req rises in N+1. If io_ack arrives in cycle K (K >= N+1), ReadDataW is valid in K+1. Stall cycles = K-N.
- Minimum IO access: ack in N+1, giving 1 stall cycle.
- Timeout completion is in cycle N+IO_TIMEOUT.
- io_ack outside REQ is ignored. io_addr, io_wdata and io_we are stable for every cycle io_req=1.
- Back-to-back IO accesses: the FSM passes through IDLE for at least one cycle between requests, so io_req deasserts for at least one cycle.
- Reset during REQ: io_req drops immediately and the in-flight access is abandoned (no WB write).

## Test plan
- Store 32'hCAFE_0001 to 0x40, then load 0x40: ReadDataW=32'hCAFE_0001 with RegWriteW=1 one cycle after the load enters MEM; StallM never asserts.
- IO load at 0x0001_0010, with io_ack and io_rdata=32'h1234_5678 on the 3rd REQ cycle: StallM is high for exactly 3 cycles, one bubble is inserted per stall cycle, and ReadDataW=32'h1234_5678.
- IO store with io_ack never asserted and IO_TIMEOUT=16: completes after 16 cycles, io_err=1 and stays 1.
- Load from unmapped 0x8000: ReadDataW=0, no stall, no io_req.
- Reset asserted on the 2nd REQ cycle: io_req=0 asynchronously and all outputs 0. A RAM load after release works normally.
- Two consecutive IO loads, each acked on the first REQ cycle: io_req shows a gap of at least one cycle, and each load produces a correct, separate WB write.
